// File: rtl/imem_dm_sync_pkg.sv
// Shared types for the funRV32 IM/DM coherence controller: sync FSM encoding and clog2.
package funrv32_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StRead,
    StWrite,
    StDone
  } sync_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/imem_dm_sync_if.sv
// Core fetch/LSU ports and external IM/DM RAM ports of the coherence controller.
interface imem_dm_sync_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
);
  logic                  i_im_ren;
  logic [ADDR_W-1:0]     i_im_addr;
  logic [DATA_W-1:0]     o_im_rdata;
  logic                  o_im_rvalid;
  logic                  i_dm_ren;
  logic                  i_dm_wen;
  logic [DATA_W/8-1:0]   i_dm_ben;
  logic [ADDR_W-1:0]     i_dm_addr;
  logic [DATA_W-1:0]     i_dm_wdata;
  logic [DATA_W-1:0]     o_dm_rdata;
  logic                  o_dm_rvalid;
  logic                  i_fence_i;
  logic                  o_ready;
  logic                  o_sync_busy;
  logic [ADDR_W-1:0]     m_im_addr;
  logic [DATA_W-1:0]     m_im_wdata;
  logic                  m_im_wen;
  logic                  m_im_ren;
  logic [DATA_W-1:0]     m_im_rdata;
  logic [ADDR_W-1:0]     m_dm_addr;
  logic [DATA_W-1:0]     m_dm_wdata;
  logic [DATA_W/8-1:0]   m_dm_ben;
  logic                  m_dm_wen;
  logic                  m_dm_ren;
  logic [DATA_W-1:0]     m_dm_rdata;

  // Controller side.
  modport slave (
    input  i_im_ren, i_im_addr, i_dm_ren, i_dm_wen, i_dm_ben, i_dm_addr, i_dm_wdata,
    input  i_fence_i, m_im_rdata, m_dm_rdata,
    output o_im_rdata, o_im_rvalid, o_dm_rdata, o_dm_rvalid, o_ready, o_sync_busy,
    output m_im_addr, m_im_wdata, m_im_wen, m_im_ren,
    output m_dm_addr, m_dm_wdata, m_dm_ben, m_dm_wen, m_dm_ren
  );

  // Core plus RAM environment side.
  modport master (
    output i_im_ren, i_im_addr, i_dm_ren, i_dm_wen, i_dm_ben, i_dm_addr, i_dm_wdata,
    output i_fence_i, m_im_rdata, m_dm_rdata,
    input  o_im_rdata, o_im_rvalid, o_dm_rdata, o_dm_rvalid, o_ready, o_sync_busy,
    input  m_im_addr, m_im_wdata, m_im_wen, m_im_ren,
    input  m_dm_addr, m_dm_wdata, m_dm_ben, m_dm_wen, m_dm_ren
  );
endinterface

// File: rtl/imem_dm_sync_dirty_log.sv
// Dirty-address FIFO: logs DM write addresses, registered read port at rd_ptr, bulk clear.
module dirty_log
  import funrv32_pkg::*;
#(
  parameter  int unsigned ADDR_W    = 14,
  parameter  int unsigned LOG_DEPTH = 256,
  localparam int unsigned LOG_AW    = clog2(LOG_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic              i_rd_en,
  input  logic              i_pop,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [LOG_AW-1:0] o_wr_ptr,
  output logic [LOG_AW-1:0] o_rd_ptr,
  output logic [LOG_AW:0]   o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W-1:0] o_last_addr
);

  localparam logic [LOG_AW:0] CountFull = (LOG_AW+1)'(LOG_DEPTH);

  logic [ADDR_W-1:0] mem_q [LOG_DEPTH];
  logic [LOG_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_AW:0]   count_q, count_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    last_d    = last_q;
    rd_addr_d = rd_addr_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (i_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
        last_d   = i_push_addr;
      end
      if (i_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (i_rd_en) rd_addr_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[wr_ptr_q] <= i_push_addr;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_q    <= '0;
      rd_addr_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_q    <= last_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign o_rd_addr   = rd_addr_q;
  assign o_wr_ptr    = wr_ptr_q;
  assign o_rd_ptr    = rd_ptr_q;
  assign o_count     = count_q;
  assign o_full      = (count_q == CountFull);
  assign o_empty     = (count_q == '0);
  assign o_last_addr = last_q;

endmodule

// File: rtl/imem_dm_sync.sv
// IM/DM coherence controller: logs DM writes and copies them into IM on fence.i or full log.
// Optional build macro DIRTY_DEDUP_EN: skip logging a write to the most recently logged address.
module imem_dm_sync
  import funrv32_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LOG_DEPTH = 256
) (
  input logic            i_clk,
  input logic            i_rst,
  imem_dm_sync_if.slave  bus
);

  localparam int unsigned     LOG_AW  = clog2(LOG_DEPTH);
  localparam logic [LOG_AW:0] LogLast = (LOG_AW+1)'(LOG_DEPTH - 1);

  sync_state_e state_q, state_d;

  logic              ready;
  logic              fence_acc;
  logic              dm_wr_acc;
  logic              push;
  logic              log_rd_en;
  logic              log_pop;
  logic              log_clear;
  logic [ADDR_W-1:0] log_entry;
  logic [LOG_AW-1:0] log_wr_ptr;
  logic [LOG_AW-1:0] log_rd_ptr;
  logic [LOG_AW-1:0] rd_next;
  logic [LOG_AW:0]   log_count;
  logic              log_full;
  logic              log_empty;
  logic [ADDR_W-1:0] log_last_addr;
  logic              im_rvalid_q;
  logic              dm_rvalid_q;

  assign ready     = !i_rst && (state_q == StIdle) && !log_full;
  assign fence_acc = ready && bus.i_fence_i;
  assign dm_wr_acc = ready && bus.i_dm_wen;
  assign rd_next   = log_rd_ptr + LOG_AW'(1);

`ifdef DIRTY_DEDUP_EN
  assign push = dm_wr_acc && !(!log_empty && (bus.i_dm_addr == log_last_addr));
`else
  assign push = dm_wr_acc;
  logic unused_last_addr;
  assign unused_last_addr = ^log_last_addr;
`endif

  dirty_log #(
    .ADDR_W    (ADDR_W),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_dirty_log (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (log_clear),
    .i_push      (push),
    .i_push_addr (bus.i_dm_addr),
    .i_rd_en     (log_rd_en),
    .i_pop       (log_pop),
    .o_rd_addr   (log_entry),
    .o_wr_ptr    (log_wr_ptr),
    .o_rd_ptr    (log_rd_ptr),
    .o_count     (log_count),
    .o_full      (log_full),
    .o_empty     (log_empty),
    .o_last_addr (log_last_addr)
  );

  always_comb begin
    state_d   = state_q;
    log_rd_en = 1'b0;
    log_pop   = 1'b0;
    log_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A write that fills the log starts the sync on the very next cycle.
        if (fence_acc || log_full || (push && (log_count == LogLast))) begin
          state_d = (!log_empty || push) ? StFetch : StDone;
        end
      end
      StFetch: begin
        log_rd_en = 1'b1;
        state_d   = StRead;
      end
      StRead:  state_d = StWrite;
      StWrite: begin
        log_pop = 1'b1;
        state_d = (rd_next != log_wr_ptr) ? StFetch : StDone;
      end
      StDone: begin
        log_clear = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    bus.m_im_addr  = bus.i_im_addr;
    bus.m_im_wdata = '0;
    bus.m_im_wen   = 1'b0;
    bus.m_im_ren   = ready && bus.i_im_ren;
    bus.m_dm_addr  = bus.i_dm_addr;
    bus.m_dm_wdata = bus.i_dm_wdata;
    bus.m_dm_ben   = bus.i_dm_ben;
    bus.m_dm_wen   = dm_wr_acc;
    bus.m_dm_ren   = ready && bus.i_dm_ren;
    if (!i_rst) begin
      if (state_q == StRead) begin
        bus.m_dm_addr = log_entry;
        bus.m_dm_ren  = 1'b1;
      end
      if (state_q == StWrite) begin
        bus.m_im_addr  = log_entry;
        bus.m_im_wdata = bus.m_dm_rdata;
        bus.m_im_wen   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      im_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
    end else begin
      im_rvalid_q <= ready && bus.i_im_ren;
      dm_rvalid_q <= ready && bus.i_dm_ren;
    end
  end

  assign bus.o_im_rdata  = bus.m_im_rdata;
  assign bus.o_dm_rdata  = bus.m_dm_rdata;
  assign bus.o_im_rvalid = im_rvalid_q;
  assign bus.o_dm_rvalid = dm_rvalid_q;
  assign bus.o_ready     = ready;
  assign bus.o_sync_busy = (state_q != StIdle);

endmodule
